// File: rtl/uart_pkg.sv
// Shared UART RX definitions: write-controller state encoding and default widths.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      GAP   = 2'd2,
      PAUSE = 2'd3
   } rx_wr_state_e;

   localparam int DATA_W_DEF = 8;
   localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/uart_rx_drop_ctr.sv
// Saturating event counter for characters dropped by the RX write controller.
module uart_rx_drop_ctr
   import uart_pkg::*;
#(
   parameter int W = DROP_CNT_W
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Holds at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_fifo_wr_ctrl.sv
// UART RX -> FIFO write controller with level hysteresis and sticky overrun.
// Define UART_RX_DROP_CNT_EN to build the live dropped-character counter.
module uart_rx_fifo_wr_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FIFO_AW   = 4,
   parameter int AF_MARGIN = 2,
   parameter int HYST      = 2,
   parameter bit DROP_FERR = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  rx_done,
   input  logic [DATA_W-1:0]     rx_data,
   input  logic                  rx_ferr,
   output logic                  rx_en,
   input  logic [FIFO_AW:0]      fifo_usedw,
   input  logic                  fifo_full,
   output logic                  fifo_wr_req,
   output logic [DATA_W-1:0]     fifo_wr_data,
   output logic                  ovr_flag,
   input  logic                  ovr_clr,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] PAUSE_LVL  = (FIFO_AW+1)'(DEPTH - AF_MARGIN);
   localparam logic [FIFO_AW:0] RESUME_LVL = (FIFO_AW+1)'(DEPTH - AF_MARGIN - HYST);

   rx_wr_state_e      state_q, state_d;
   logic [DATA_W-1:0] char_q, char_d;
   logic              rx_en_q, rx_en_d;
   logic              wr_req_q, wr_req_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              ovr_q, ovr_d;

   logic discard, pause_lvl, wr_go, drop_evt;

   assign discard   = DROP_FERR && rx_ferr;
   assign pause_lvl = (fifo_usedw >= PAUSE_LVL) || fifo_full;
   assign wr_go     = (state_q == WRITE) && !fifo_full;

   // Overrun: character arrives while busy or full, or the latched one finds the FIFO full.
   assign drop_evt = (rx_done && (state_q != IDLE))
                  || (rx_done && (state_q == IDLE) && !discard && fifo_full)
                  || ((state_q == WRITE) && fifo_full);

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= IDLE;
         char_q    <= '0;
         rx_en_q   <= 1'b0;
         wr_req_q  <= 1'b0;
         wr_data_q <= '0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         char_q    <= char_d;
         rx_en_q   <= rx_en_d;
         wr_req_q  <= wr_req_d;
         wr_data_q <= wr_data_d;
         ovr_q     <= ovr_d;
      end
   end

   // NOTE: each combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      unique case (state_q)
         IDLE: begin
            if (rx_done) char_d = rx_data;
            if (rx_done && !discard && !fifo_full) state_d = WRITE;
            else if (pause_lvl)                    state_d = PAUSE;
         end
         WRITE: state_d = GAP;
         GAP:   state_d = pause_lvl ? PAUSE : IDLE;
         PAUSE: if ((fifo_usedw <= RESUME_LVL) && !fifo_full) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the current state, so they trail it by one cycle.
   always_comb begin
      rx_en_d   = (state_q == IDLE);
      wr_req_d  = wr_go;
      wr_data_d = wr_go ? char_q : wr_data_q;
      ovr_d     = drop_evt || (ovr_q && !ovr_clr);
   end

   assign rx_en        = rx_en_q;
   assign fifo_wr_req  = wr_req_q;
   assign fifo_wr_data = wr_data_q;
   assign ovr_flag     = ovr_q;

`ifdef UART_RX_DROP_CNT_EN
   uart_rx_drop_ctr #(.W(DROP_CNT_W)) u_drop_ctr (
      .CLK  (CLK),
      .RSTn (RSTn),
      .inc  (drop_evt),
      .cnt  (drop_cnt)
   );
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: doc/uart_rx_fifo_wr_ctrl.md
# uart_rx_fifo_wr_ctrl

Parametrised write-side controller between the UART receiver and the RX FIFO. It takes completed characters from the receiver, writes each into the FIFO with a single-cycle write request, and throttles the receiver with FIFO-level hysteresis. Characters that cannot be stored are dropped and reported through a sticky overrun flag. Frame-errored characters can optionally be discarded. It replaces the fixed 8-bit, full-only RX manager in the UART subsystem.

## Interface
- DATA_W, 8, character width (5..9)
- FIFO_AW, 4, FIFO address width; DEPTH = 2**FIFO_AW
- AF_MARGIN, 2, free entries at which the receiver is paused (1..DEPTH-1)
- HYST, 2, extra entries that must drain before resume (0..DEPTH-AF_MARGIN)
- DROP_FERR, 1, 1 = discard characters flagged with a frame error
- CLK  in  1  system clock
- RSTn  in  1  reset, asynchronous, active-low
- rx_done  in  1  one-cycle pulse: character complete
- rx_data  in  DATA_W  character, valid with rx_done
- rx_ferr  in  1  frame error, valid with rx_done
- rx_en  out  1  receiver enable
- fifo_usedw  in  FIFO_AW+1  FIFO fill level (0..DEPTH)
- fifo_full  in  1  FIFO full
- fifo_wr_req  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_W  FIFO write data
- ovr_flag  out  1  sticky overrun
- ovr_clr  in  1  clears ovr_flag
- drop_cnt  out  16  dropped-character count

## Operation
- Reset values: state IDLE, rx_en=0, fifo_wr_req=0, fifo_wr_data=0, ovr_flag=0, drop_cnt=0.
- States:
  - IDLE: rx_en=1. On rx_done, go to WRITE. With DROP_FERR=1 and rx_ferr=1, discard the character instead and stay in IDLE; this does not count as an overrun.
  - WRITE: fifo_wr_req=1 for exactly one cycle, carrying the character latched on rx_done. Then go to GAP.
  - GAP: fifo_wr_req=0. Evaluate the fill level, then go to IDLE or PAUSE.
  - PAUSE: rx_en=0. Go to IDLE once fifo_usedw <= DEPTH-AF_MARGIN-HYST.
- Entering PAUSE: from GAP or IDLE whenever fifo_usedw >= DEPTH-AF_MARGIN, or fifo_full=1.
- Drop condition: rx_done while fifo_full=1, in WRITE, in GAP, or in PAUSE.
  - The character is not written.
  - ovr_flag is set.
  - drop_cnt increments.
- fifo_wr_req is never asserted while fifo_full=1. If full rises between capture and WRITE, the character is dropped as an overrun.
- ovr_clr has priority below a same-cycle set: the flag stays at 1.
- drop_cnt saturates at 16'hFFFF; it does not wrap. It is cleared only by reset.
- fifo_wr_data holds its last value between writes.

## Timing
- rx_done sampled at edge k:
  - fifo_wr_req is high from k+1 to k+2.
  - GAP occupies k+2 to k+3.
  - rx_en can return at k+3.
- Minimum rx_done spacing accepted without drop: 3 cycles.
- All outputs are registered. There are no combinational input-to-output paths.
- PAUSE exit: rx_en rises one cycle after fifo_usedw meets the resume threshold.
- RSTn assertion mid-operation clears state immediately. A write in flight is abandoned; fifo_wr_req drops asynchronously.

## Configuration
- UART_RX_DROP_CNT_EN defined: drop_cnt is a live saturating 16-bit counter.
- UART_RX_DROP_CNT_EN undefined: no counter logic is built and drop_cnt is tied to 0. ovr_flag behaviour is unchanged.

## Structure
- Shared package uart_pkg holds:
  - state enum (IDLE, WRITE, GAP, PAUSE)
  - DATA_W default
  - drop-counter width constant
- One sub-module: uart_rx_drop_ctr (saturating counter with increment input), instantiated only under UART_RX_DROP_CNT_EN.

## Test plan
- Reset, then rx_done with rx_data=8'hA5 at cycle 10 -> fifo_wr_req high during cycle 11 only, fifo_wr_data=8'hA5, rx_en=1 again at cycle 13.
- DEPTH=16, AF_MARGIN=2, HYST=2; fill to usedw=14 -> rx_en=0; drain to 13 -> still 0; drain to 12 -> rx_en=1 on the next cycle.
- Hold fifo_full=1, pulse rx_done -> no fifo_wr_req, ovr_flag=1, drop_cnt=1; pulse ovr_clr -> ovr_flag=0, drop_cnt stays 1.
- rx_done pulses 1 cycle apart -> first written, second dropped, drop_cnt=1. Same pulses 3 cycles apart -> both written, no drop.
- DROP_FERR=1, rx_done with rx_ferr=1, data 8'h3C -> no write, ovr_flag=0. Repeat with DROP_FERR=0 -> 8'h3C written.
- Assert RSTn low during WRITE -> fifo_wr_req=0 immediately; after release all outputs hold their reset values. Force 65537 drops -> drop_cnt=16'hFFFF.
